// File: rtl/cu_state_seq_if.sv
// rtl/cu_state_seq_if.sv - control-unit sequencer bus: instruction fields in, phase/status out
interface cu_state_seq_if #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
);
  logic               Stall;
  logic [5:0]         op;
  logic [11:0]        opfunc;
  logic [STATE_W-1:0] State;
  logic [STATE_W-1:0] NextState;
  logic               trigger;
  logic               Illegal;
  logic [CNT_W-1:0]   InstrCount;

  modport master (
    output Stall, op, opfunc,
    input  State, NextState, trigger, Illegal, InstrCount
  );

  modport slave (
    input  Stall, op, opfunc,
    output State, NextState, trigger, Illegal, InstrCount
  );
endinterface

// File: rtl/cu_state_seq.sv
// rtl/cu_state_seq.sv - multicycle IF/ID/EXE/MEM/WB phase sequencer with illegal-op flag and retire counter
// Optional HALT opcode (111111) enabled by defining CU_HALT_EN.
module cu_state_seq #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  cu_state_seq_if.slave  bus
);
  typedef enum logic [STATE_W-1:0] {
    S_INIT  = STATE_W'(4'b1111),
    S_IF    = STATE_W'(4'b0000),
    S_ID    = STATE_W'(4'b0001),
    S_EXER  = STATE_W'(4'b0010),
    S_EXEI  = STATE_W'(4'b0011),
    S_EXEB  = STATE_W'(4'b0100),
    S_EXEW  = STATE_W'(4'b0101),
    S_MEMSW = STATE_W'(4'b0110),
    S_MEMLW = STATE_W'(4'b0111),
    S_WBR   = STATE_W'(4'b1000),
    S_WBI   = STATE_W'(4'b1001),
    S_WBLW  = STATE_W'(4'b1010),
    S_WBJAR = STATE_W'(4'b1011),
    S_HALT  = STATE_W'(4'b1110)
  } state_t;

  localparam logic [11:0] JR_OPFUNC = 12'b000000_001000;

  state_t           state;
  state_t           next_state;
  logic             illegal_op;
  logic             trigger_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    next_state = S_IF;
    illegal_op = 1'b0;
    case (state)
      S_INIT: next_state = S_IF;
      S_IF:   next_state = S_ID;
      S_ID: begin
        casez (bus.op)
          6'b000000: next_state = (bus.opfunc == JR_OPFUNC) ? S_IF : S_EXER;
          6'b000010: next_state = S_IF;
          6'b000011: next_state = S_WBJAR;
          6'b00010?: next_state = S_EXEB;
          6'b001???: next_state = S_EXEI;
          6'b100011,
          6'b101011: next_state = S_EXEW;
`ifdef CU_HALT_EN
          6'b111111: next_state = S_HALT;
`endif
          default: begin
            next_state = S_IF;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_EXER:  next_state = S_WBR;
      S_EXEI:  next_state = S_WBI;
      S_EXEB:  next_state = S_IF;
      S_EXEW:  next_state = (bus.op == 6'b101011) ? S_MEMSW : S_MEMLW;
      S_MEMSW: next_state = S_IF;
      S_MEMLW: next_state = S_WBLW;
`ifdef CU_HALT_EN
      S_HALT:  next_state = S_HALT;
`endif
      default: next_state = S_IF;
    endcase
  end

  // A stalled edge freezes everything except the illegal pulse, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      trigger_q <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (bus.Stall) begin
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      trigger_q <= ~trigger_q;
      illegal_q <= illegal_op;
      if (state != S_INIT && next_state == S_IF)
        count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.State      = state;
  assign bus.NextState  = next_state;
  assign bus.trigger    = trigger_q;
  assign bus.Illegal    = illegal_q;
  assign bus.InstrCount = count_q;
endmodule

// File: tb/tb_cu_state_seq.sv
// tb/tb_cu_state_seq.sv - randomized scoreboard bench for cu_state_seq against a per-instruction phase-path model
module tb_cu_state_seq;
  localparam int CNT_W = 8;

  localparam logic [3:0] ST_INIT  = 4'b1111;
  localparam logic [3:0] ST_IF    = 4'b0000;
  localparam logic [3:0] ST_ID    = 4'b0001;
  localparam logic [3:0] ST_EXER  = 4'b0010;
  localparam logic [3:0] ST_EXEI  = 4'b0011;
  localparam logic [3:0] ST_EXEB  = 4'b0100;
  localparam logic [3:0] ST_EXEW  = 4'b0101;
  localparam logic [3:0] ST_MEMSW = 4'b0110;
  localparam logic [3:0] ST_MEMLW = 4'b0111;
  localparam logic [3:0] ST_WBR   = 4'b1000;
  localparam logic [3:0] ST_WBI   = 4'b1001;
  localparam logic [3:0] ST_WBLW  = 4'b1010;
  localparam logic [3:0] ST_WBJAR = 4'b1011;
  localparam logic [3:0] ST_HALT  = 4'b1110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cu_state_seq_if #(.STATE_W(4), .CNT_W(CNT_W)) bus ();

  cu_state_seq #(.STATE_W(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [3:0]       ns;
    logic             trig;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   force_halt = 1'b0;

  // Model: each instruction is the list of phases it visits after IF.
  logic [3:0]       cur;
  logic [3:0]       path[$];
  bit               cur_illegal;
  logic [5:0]       cur_op;
  logic [5:0]       cur_funct;
  logic             m_trig;
  logic             m_ill;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_path();
    cur_illegal = 1'b0;
    if (cur_op == 6'd0 && cur_funct == 6'd8)       path = '{ST_ID, ST_IF};
    else if (cur_op == 6'd0)                       path = '{ST_ID, ST_EXER, ST_WBR, ST_IF};
    else if (cur_op == 6'd2)                       path = '{ST_ID, ST_IF};
    else if (cur_op == 6'd3)                       path = '{ST_ID, ST_WBJAR, ST_IF};
    else if (cur_op == 6'd4 || cur_op == 6'd5)     path = '{ST_ID, ST_EXEB, ST_IF};
    else if (cur_op >= 6'd8 && cur_op <= 6'd15)    path = '{ST_ID, ST_EXEI, ST_WBI, ST_IF};
    else if (cur_op == 6'd35)                      path = '{ST_ID, ST_EXEW, ST_MEMLW, ST_WBLW, ST_IF};
    else if (cur_op == 6'd43)                      path = '{ST_ID, ST_EXEW, ST_MEMSW, ST_IF};
`ifdef CU_HALT_EN
    else if (cur_op == 6'd63)                      path = '{ST_ID, ST_HALT};
`endif
    else begin
      path = '{ST_ID, ST_IF};
      cur_illegal = 1'b1;
    end
  endtask

  task automatic pick_op();
    int r;
    r = $urandom_range(0, 11);
    cur_funct = 6'($urandom);
    case (r)
      0:  cur_op = 6'd0;
      1:  begin cur_op = 6'd0; cur_funct = 6'd8; end
      2:  cur_op = 6'd2;
      3:  cur_op = 6'd3;
      4:  cur_op = 6'd4;
      5:  cur_op = 6'd5;
      6:  cur_op = 6'(8 + $urandom_range(0, 7));
      7:  cur_op = 6'd35;
      8:  cur_op = 6'd43;
      9:  begin
        cur_op = 6'($urandom);
`ifdef CU_HALT_EN
        if (cur_op == 6'd63) cur_op = 6'd16;
`endif
      end
      10: cur_op = 6'd16;
      default: begin
`ifdef CU_HALT_EN
        cur_op = 6'd35;
`else
        cur_op = 6'd63;
`endif
      end
    endcase
    if (force_halt) cur_op = 6'd63;
    build_path();
  endtask

  task automatic push_exp();
    exp_t e;
    e.st   = cur;
    e.ns   = (cur == ST_INIT) ? ST_IF : path[0];
    e.trig = m_trig;
    e.ill  = m_ill;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input bit stall);
    logic [3:0] nxt;
    if (stall) begin
      m_ill = 1'b0;
    end else begin
      if (cur == ST_INIT) nxt = ST_IF;
      else nxt = path.pop_front();
      if (nxt == ST_HALT) path.push_back(ST_HALT);
      m_ill = (cur == ST_ID) && cur_illegal;
      if (nxt == ST_IF && cur != ST_INIT) m_cnt = m_cnt + 1'b1;
      m_trig = ~m_trig;
      cur = nxt;
      if (cur == ST_IF) pick_op();
    end
    push_exp();
  endtask

  // Called just after a rising edge: drive inputs for the next edge and predict its result.
  task automatic drive_cycle();
    bit stall;
    if (cur == ST_ID || cur == ST_EXEW) begin
      bus.op     = cur_op;
      bus.opfunc = {cur_op, cur_funct};
    end else begin
      bus.op     = 6'($urandom);
      bus.opfunc = 12'($urandom);
    end
    stall = ($urandom_range(0, 4) == 0);
    bus.Stall = stall;
    model_edge(stall);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("State",      32'(bus.State),      32'(e.st));
          check("NextState",  32'(bus.NextState),  32'(e.ns));
          check("trigger",    32'(bus.trigger),    32'(e.trig));
          check("Illegal",    32'(bus.Illegal),    32'(e.ill));
          check("InstrCount", 32'(bus.InstrCount), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    bus.Stall  = 1'b0;
    bus.op     = 6'd0;
    bus.opfunc = 12'd0;
    cur    = ST_INIT;
    m_trig = 1'b0;
    m_ill  = 1'b0;
    m_cnt  = '0;
    path.delete();
    cur_illegal = 1'b0;
    cur_op = 6'd0;
    cur_funct = 6'd0;

    repeat (2) @(posedge clk);
    #1;
    push_exp();
    mon_en = 1'b1;
    rst_n  = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
`ifdef CU_HALT_EN
    force_halt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
`endif

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Asynchronous reset away from any clock edge, mid-instruction.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_State",      32'(bus.State),      32'(ST_INIT));
    check("async_reset_NextState",  32'(bus.NextState),  32'(ST_IF));
    check("async_reset_trigger",    32'(bus.trigger),    32'd0);
    check("async_reset_Illegal",    32'(bus.Illegal),    32'd0);
    check("async_reset_InstrCount", 32'(bus.InstrCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
